// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and constants for the adder_arbiter block.
//   state_t : arbiter FSM encoding (IDLE/EXEC/DONE)
//   STAT_W  : width of each per-requester grant counter
package adder_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/adder.sv
// adder: registered unsigned adder, one cycle of latency.
//   clk : clock
//   inA : operand A (W bits)
//   inB : operand B (W bits)
//   out : registered inA + inB, carry included (W+1 bits)
module adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic [W-1:0] inA,
    input  logic [W-1:0] inB,
    output logic [W:0]   out
);

    always_ff @(posedge clk) begin
        out <= {1'b0, inA} + {1'b0, inB};
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one registered adder among N
// requesters. One operation in flight: IDLE (accept) -> EXEC (adder
// registers) -> DONE (hold result until rsp_ready).
//   clk, reset  : clock, synchronous active-high reset
//   req_valid   : per-requester pending flag (N)
//   req_a/req_b : packed operands, requester i at [i*W +: W]
//   req_ready   : one-hot grant, only in IDLE
//   rsp_valid/rsp_id/rsp_sum/rsp_ready : result channel with backpressure
//   busy        : FSM not in IDLE
//   grant_count : (ADDER_ARB_STATS_EN only) 16-bit accepted-grant counter
//                 per requester, slice i at [i*16 +: 16]
// Optional feature macro: ADDER_ARB_STATS_EN
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic             rsp_valid,
    output logic [IDW-1:0]   rsp_id,
    output logic [W:0]       rsp_sum,
    input  logic             rsp_ready,
`ifdef ADDER_ARB_STATS_EN
    output logic [N*STAT_W-1:0] grant_count,
`endif
    output logic             busy
);

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [W-1:0]   r_a, r_b;
    logic [IDW-1:0] r_id;

    logic           w_found;
    logic [IDW-1:0] w_gidx;
    logic           w_accept;
    logic [W:0]     w_sum;

    // Round-robin search: first valid at or after r_ptr, wrapping mod N.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_gidx  = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_gidx  = IDW'(idx);
            end
        end
    end

    assign w_accept = (r_state == IDLE) && w_found;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_gidx] = 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found)   w_state_nxt = EXEC;
            EXEC:                   w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Operand/ID capture; held until the next acceptance so the registered
    // adder output stays constant through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= '0;
        end else if (w_accept) begin
            r_a   <= req_a[w_gidx*W +: W];
            r_b   <= req_b[w_gidx*W +: W];
            r_id  <= w_gidx;
            r_ptr <= (w_gidx == IDW'(N-1)) ? '0 : w_gidx + 1'b1;
        end
    end

    adder #(.W(W)) u_adder (
        .clk (clk),
        .inA (r_a),
        .inB (r_b),
        .out (w_sum)
    );

    assign rsp_valid = (r_state == DONE);
    assign rsp_sum   = w_sum;
    assign rsp_id    = r_id;
    assign busy      = (r_state != IDLE);

`ifdef ADDER_ARB_STATS_EN
    logic [N-1:0][STAT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset)         r_cnt <= '0;
        else if (w_accept) r_cnt[w_gidx] <= r_cnt[w_gidx] + 1'b1;
    end

    assign grant_count = r_cnt;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;
    import adder_arb_pkg::*;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [N-1:0]     req_ready;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W:0]       rsp_sum;
    logic             rsp_ready;
    logic             busy;
`ifdef ADDER_ARB_STATS_EN
    logic [N*STAT_W-1:0] grant_count;
`endif

    adder_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready),
`ifdef ADDER_ARB_STATS_EN
        .grant_count (grant_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct { int id; int sum; } exp_t;
    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   exp_cnt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected result pushed on each handshake, popped on each
    // response handshake. Reset flushes everything in flight.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("sb_id",  32'(rsp_id),  32'(e.id));
                    chk("sb_sum", 32'(rsp_sum), 32'(e.sum));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id  = i;
                    e.sum = int'(req_a[i*W +: W]) + int'(req_b[i*W +: W]);
                    q.push_back(e);
                    exp_cnt[i] = (exp_cnt[i] + 1) % 65536;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();

        // Single request from requester 0
        reset = 1'b0;
        req_valid = 4'b0001; req_a[0 +: W] = 8'd5; req_b[0 +: W] = 8'd6;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        tick(); req_valid = '0;
        chk("exec_busy",  32'(busy),      32'd1);
        chk("exec_valid", 32'(rsp_valid), 32'd0);
        chk("exec_ready", 32'(req_ready), 32'd0);
        tick();
        chk("single_valid", 32'(rsp_valid), 32'd1);
        chk("single_id",    32'(rsp_id),    32'd0);
        chk("single_sum",   32'(rsp_sum),   32'd11);
        tick();

        // Carry, requester 2 (ptr is 1)
        req_valid = 4'b0100; req_a[2*W +: W] = 8'hFF; req_b[2*W +: W] = 8'hFF;
        #1;
        chk("carry_ready", 32'(req_ready), 32'b0100);
        tick(); req_valid = '0;
        tick();
        chk("carry_id",  32'(rsp_id),  32'd2);
        chk("carry_sum", 32'(rsp_sum), 32'h1FE);
        tick();

        // Fairness from a fresh pointer
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = 8'(i*10 + 1);
            req_b[i*W +: W] = 8'(i + 100);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_grant", 32'(req_ready), 32'(1 << (k % N)));
            tick();
            chk("fair_exec_ready", 32'(req_ready), 32'd0);
            tick();
            chk("fair_id", 32'(rsp_id), 32'(k % N));
            tick();
        end

        // Backpressure: ptr is 1, only requester 0 valid -> wraps to 0
        req_valid = 4'b0001;
        #1;
        chk("bp_grant0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0010; rsp_ready = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_id",    32'(rsp_id),    32'd0);
            chk("bp_sum",   32'(rsp_sum),   32'd101);
            chk("bp_ready", 32'(req_ready), 32'd0);
            if (c < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        tick(); req_valid = '0;
        tick();
        chk("bp_id1",  32'(rsp_id),  32'd1);
        chk("bp_sum1", 32'(rsp_sum), 32'd112);
        tick();

        // Reset mid-operation (ptr is 2 -> grant 2, then abort in EXEC)
        req_valid = 4'b0100;
        tick();
        req_valid = '0; reset = 1'b1;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        tick();
        reset = 1'b0;
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy",  32'(busy),      32'd0);
        // ptr back to 0: with 0 and 3 pending, 0 wins
        req_valid = 4'b1001;
        #1;
        chk("abort_ptr", 32'(req_ready), 32'b0001);
        tick(); req_valid = 4'b1000;
        tick();
        tick();
        // requester 3 alone, ptr at 1 wraps forward to 3
        #1;
        chk("abort_req3", 32'(req_ready), 32'b1000);
        tick(); req_valid = '0;
        tick();
        chk("req3_id", 32'(rsp_id), 32'd3);
        tick();
        tick();

        chk("sb_drained", 32'(q.size()), 32'd0);
`ifdef ADDER_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("grant_count", 32'(grant_count[i*STAT_W +: STAT_W]), 32'(exp_cnt[i]));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
